spi_master_cfg: RTL and testbench
=================================

// Module: spi_master_cfg
// PURPOSE
//  Parametrised full-duplex SPI master: configurable word width, SCLK divider, chip-select count and
//  all four SPI modes (CPOL/CPHA), with a start/ready/rx_valid handshake to the host logic.
//  It shifts tx_data out on MOSI and captures MISO into rx_data. It sits between board-level
//  control FSMs and external SPI slaves. SCLK is a registered output in the clk domain, not a derived clock.
// PARAMETERS
//  DATA_W   8  bits per frame, MSB first; legal range >= 2
//  CLK_DIV  4  clk cycles per SCLK half-period; legal range >= 2
//  NUM_CS   1  number of active-low chip selects
//  CS_W     derived, max(1,$clog2(NUM_CS)); width of cs_sel
// PORTS
//  clk      in   1       system clock; single clock domain
//  reset    in   1       synchronous, active-high reset
//  start    in   1       request a frame; accepted only when ready=1
//  ready    out  1       1 = idle and able to accept start
//  cpol     in   1       SCLK idle level; latched when start is accepted
//  cpha     in   1       0: sample on leading edge; 1: sample on trailing edge; latched when start is accepted
//  cs_sel   in   CS_W    target slave index; latched when start is accepted
//  tx_data  in   DATA_W  word to transmit; latched when start is accepted
//  rx_data  out  DATA_W  last received word; holds its value until the next frame completes
//  rx_valid out  1       one-clk pulse when rx_data updates
//  spi_clk  out  1       SCLK
//  cs_n     out  NUM_CS  chip selects, active low
//  mosi     out  1       serial data out
//  miso     in   1       serial data in
// BEHAVIOUR
//  Reset values: ready=1, rx_valid=0, rx_data=0, spi_clk=0, cs_n=all 1, mosi=1; FSM enters IDLE; divider cleared.
//  Half-period tick: divider counts 0..CLK_DIV-1 while not in IDLE; tick = (cnt==CLK_DIV-1).
//  FSM states and transitions:
//   IDLE:  ready=1; spi_clk follows the cpol input, registered; mosi=1.
//          On start&ready: latch cfg and tx_data into shift_reg, set cs_n[cs_sel]=0, ready=0, go to SETUP.
//          If cs_sel>=NUM_CS, the frame runs with all cs_n high.
//   SETUP: lasts 1 half-period. If cpha=0, mosi=shift_reg MSB from the start of SETUP. On tick, go to XFER.
//   XFER:  lasts 2*DATA_W half-periods. spi_clk toggles on each tick; a 0..2*DATA_W-1 edge counter tracks edges.
//          Leading edge = toggle away from cpol; trailing edge = toggle back to cpol.
//          cpha=0: sample miso on leading edges; shift mosi on trailing edges, except the final one.
//          cpha=1: shift mosi on leading edges (first leading edge drives MSB); sample miso on trailing edges.
//          After the last edge, spi_clk=cpol; go to HOLD.
//   HOLD:  lasts 1 half-period with CS still asserted. On tick: cs_n=all 1, mosi=1, rx_data<=shifted word,
//          rx_valid=1 for exactly that cycle, go to GAP.
//   GAP:   lasts 1 half-period with CS deasserted; this guarantees a minimum CS-high time. On tick, go to IDLE with ready=1.
//  Timing, for start accepted at clk edge E0:
//   rx_valid is high in the cycle after edge E0+CLK_DIV*(2*DATA_W+2).
//   ready returns at edge E0+CLK_DIV*(2*DATA_W+3).
//  Mosi stability: mosi never changes on a sampling edge; it is stable >= CLK_DIV-1 clks before each sampling edge.
//  Boundary conditions:
//   start while ready=0 is ignored, with no queueing.
//   start held high gives back-to-back frames separated by GAP.
//   tx_data, cpol, cpha and cs_sel changes mid-frame have no effect.
//   reset mid-frame: at the next edge, all outputs return to reset values; no rx_valid; the partial word is discarded.
//  Width rules: shift_reg and rx shift are DATA_W wide; the edge counter is $clog2(2*DATA_W) wide; no wrap within a frame.
// STRUCTURE
//  Shared include spi_defs.vh holds:
//   state encodings ST_IDLE/ST_SETUP/ST_XFER/ST_HOLD/ST_GAP;
//   mode constants SPI_MODE0..3 as {cpol,cpha}.
//  One sub-module, spi_clk_tick: the CLK_DIV half-period tick counter with synchronous clear.
//  FSM, shifters and CS decode stay in this module.
// TESTING
//  Test 1, mode 0: DATA_W=8, CLK_DIV=4, tx_data=0xA5, miso looped to mosi.
//   Expect rx_data=0xA5, one rx_valid pulse after edge E0+72, ready at edge E0+76, 8 rising SCLK edges.
//  Test 2, mode 3: tx_data=0x3C; slave model returns 0xC3.
//   Expect spi_clk idle high, rx_data=0xC3, slave model receives 0x3C.
//  Test 3, start while busy: start pulse with tx_data=0xFF at cycle 20 of a 0xA5 frame.
//   Expect the pulse ignored, MOSI pattern still 0xA5, exactly one rx_valid.
//  Test 4, reset mid-frame: reset at cycle 30.
//   Expect at the next edge cs_n=all 1, spi_clk=0, mosi=1, ready=1, rx_data=0, no rx_valid.
//  Test 5, multi-CS: NUM_CS=4, cs_sel=2, start held high.
//   Expect cs_n=4'b1011 during frames, >=CLK_DIV clks of 4'b1111 between frames.
//  Test 6, modes 1 and 2: a checker asserts mosi is stable across every sampling edge and spi_clk returns to cpol after 2*DATA_W edges.

Source files
------------

// File: rtl/spi_master_cfg_pkg.sv
// spi_master_cfg_pkg: FSM state encoding, SPI mode constants and width helper for the SPI master.
package spi_master_cfg_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD, ST_GAP} state_e;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  function automatic int cs_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_master_cfg_if.sv
// spi_master_cfg_if: host handshake and SPI pin bundle; master is the SPI engine side, slave the host side.
interface spi_master_cfg_if import spi_master_cfg_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int CS_W = cs_width(NUM_CS)
) ();
  logic start, ready, cpol, cpha, rx_valid, spi_clk, mosi, miso;
  logic [CS_W-1:0] cs_sel;
  logic [DATA_W-1:0] tx_data, rx_data;
  logic [NUM_CS-1:0] cs_n;
  modport master (
    input start, cpol, cpha, cs_sel, tx_data, miso,
    output ready, rx_data, rx_valid, spi_clk, cs_n, mosi
  );
  modport slave (
    output start, cpol, cpha, cs_sel, tx_data, miso,
    input ready, rx_data, rx_valid, spi_clk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master_cfg_tick.sv
// spi_clk_tick: half-period counter pulsing tick_o every CLK_DIV clks, held at zero while clr_i.
module spi_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CW'(CLK_DIV - 1);
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: full-duplex SPI master with configurable width, divider, chip selects and CPOL/CPHA.
module spi_master_cfg import spi_master_cfg_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS = 1
) (
  input logic clk,
  input logic reset,
  spi_master_cfg_if.master bus
);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);
  localparam logic [NUM_CS-1:0] CS_ONE = NUM_CS'(1);
  state_e state_q, state_d;
  logic cpha_q, cpha_d, sclk_q, sclk_d, mosi_q, mosi_d, rxv_q, rxv_d, tick;
  logic [DATA_W-1:0] shift_q, shift_d, rx_sh_q, rx_sh_d, rxd_q, rxd_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [NUM_CS-1:0] csn_q, csn_d;
  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clr_i(state_q == ST_IDLE),
    .tick_o(tick)
  );
  assign bus.ready = state_q == ST_IDLE;
  assign bus.rx_data = rxd_q;
  assign bus.rx_valid = rxv_q;
  assign bus.spi_clk = sclk_q;
  assign bus.cs_n = csn_q;
  assign bus.mosi = mosi_q;
  always_comb begin
    state_d = state_q;
    cpha_d = cpha_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    rxv_d = 1'b0;
    shift_d = shift_q;
    rx_sh_d = rx_sh_q;
    rxd_d = rxd_q;
    edge_cnt_d = edge_cnt_q;
    csn_d = csn_q;
    case (state_q)
      ST_IDLE: begin
        sclk_d = bus.cpol;
        mosi_d = 1'b1;
        if (bus.start) begin
          cpha_d = bus.cpha;
          shift_d = bus.tx_data;
          // an out-of-range index shifts the one-hot out entirely, leaving every select high
          csn_d = ~(CS_ONE << bus.cs_sel);
          mosi_d = bus.cpha ? 1'b1 : bus.tx_data[DATA_W-1];
          edge_cnt_d = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = tick ? ST_XFER : ST_SETUP;
      ST_XFER: if (tick) begin
        sclk_d = ~sclk_q;
        edge_cnt_d = edge_cnt_q + 1'b1;
        if (~edge_cnt_q[0] ^ cpha_q) rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.miso};
        else if (edge_cnt_q != LAST) begin
          mosi_d = cpha_q ? shift_q[DATA_W-1] : shift_q[DATA_W-2];
          shift_d = shift_q << 1;
        end
        if (edge_cnt_q == LAST) begin
          edge_cnt_d = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: if (tick) begin
        csn_d = '1;
        mosi_d = 1'b1;
        rxd_d = rx_sh_q;
        rxv_d = 1'b1;
        state_d = ST_GAP;
      end
      ST_GAP: state_d = tick ? ST_IDLE : ST_GAP;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ST_IDLE;
      cpha_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b1;
      rxv_q <= 1'b0;
      shift_q <= '0;
      rx_sh_q <= '0;
      rxd_q <= '0;
      edge_cnt_q <= '0;
      csn_q <= '1;
    end else begin
      state_q <= state_d;
      cpha_q <= cpha_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      rxv_q <= rxv_d;
      shift_q <= shift_d;
      rx_sh_q <= rx_sh_d;
      rxd_q <= rxd_d;
      edge_cnt_q <= edge_cnt_d;
      csn_q <= csn_d;
    end
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed and random frames in all SPI modes checked against a behavioural SPI slave.
module tb_spi_master_cfg;
  localparam int DW = 8;
  localparam int CD = 4;
  localparam int NC = 4;
  logic clk = 1'b0;
  logic reset;
  logic loopb, s_miso;
  int total = 0, bad = 0;
  logic [7:0] s_tx, s_rx;
  logic m_cpol, m_cpha, prev_sclk, prev_mosi, prev_act;
  int m_sel, age, rises, stab_bad;
  always #5 clk = ~clk;
  spi_master_cfg_if #(.DATA_W(DW), .NUM_CS(NC)) bus ();
  spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(NC)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.miso = loopb ? bus.mosi : s_miso;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clk, then a behavioural SPI slave and pin monitor look at the settled outputs
  task automatic step();
    logic act, lead;
    @(negedge clk);
    age = (bus.mosi === prev_mosi) ? age + 1 : 0;
    act = bus.cs_n[m_sel] === 1'b0;
    if (act && !prev_act && !m_cpha) s_miso = s_tx[7];
    if (act && bus.spi_clk !== prev_sclk) begin
      lead = bus.spi_clk != m_cpol;
      if (bus.spi_clk) rises++;
      if (lead ^ m_cpha) begin
        s_rx = {s_rx[6:0], bus.mosi};
        if (age < CD - 1) stab_bad++;
      end else if (m_cpha) begin
        s_miso = s_tx[7];
        s_tx = s_tx << 1;
      end else begin
        s_tx = s_tx << 1;
        s_miso = s_tx[7];
      end
    end
    prev_sclk = bus.spi_clk;
    prev_mosi = bus.mosi;
    prev_act = act;
  endtask

  task automatic arm(input logic [7:0] sw, input logic cp, input logic ch, input int sel);
    m_cpol = cp;
    m_cpha = ch;
    m_sel = sel;
    s_tx = sw;
    s_rx = '0;
    s_miso = 1'b0;
    rises = 0;
    stab_bad = 0;
  endtask

  task automatic run_frame(input logic [7:0] tx, input logic [7:0] sw, input logic cp, input logic ch,
                           input int sel, input logic lp, input logic poke);
    int vk, vcnt, rk;
    logic [3:0] cs_mid;
    logic sclk_end;
    vk = -1; vcnt = 0; rk = -1; cs_mid = 'x; sclk_end = 1'bx;
    bus.cpol = cp; bus.cpha = ch; bus.cs_sel = 2'(sel); loopb = lp;
    step();
    step();
    chk("idle_sclk", 32'(bus.spi_clk), 32'(cp));
    arm(sw, cp, ch, sel);
    bus.tx_data = tx;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.rx_valid) begin
        vcnt++;
        if (vk < 0) vk = k;
      end
      if (k == 10) cs_mid = bus.cs_n;
      if (k == 74) sclk_end = bus.spi_clk;
      if (bus.ready) begin
        rk = k;
        break;
      end
      if (poke && k == 20) begin
        bus.start = 1'b1; bus.tx_data = 8'hFF; bus.cpol = ~cp; bus.cpha = ~ch; bus.cs_sel = 2'(sel ^ 1);
      end
      if (poke && k == 21) bus.start = 1'b0;
      step();
    end
    chk("rx_valid_at", 32'(vk), 32'(CD * (2 * DW + 2)));
    chk("rx_valid_cnt", 32'(vcnt), 32'd1);
    chk("ready_at", 32'(rk), 32'(CD * (2 * DW + 3)));
    chk("rx_data", 32'(bus.rx_data), 32'(lp ? tx : sw));
    chk("slave_rx", 32'(s_rx), 32'(tx));
    chk("sclk_rises", 32'(rises), 32'(DW));
    chk("sclk_end", 32'(sclk_end), 32'(cp));
    chk("cs_mid", 32'(cs_mid), 32'(4'hF & ~(4'b1 << sel)));
    chk("mosi_stable", 32'(stab_bad), 32'd0);
    chk("cs_idle", 32'(bus.cs_n), 32'hF);
  endtask

  initial begin
    int vcnt, hi_run, min_gap, csbad;
    logic had_low;
    logic [7:0] tx, sw;
    reset = 1'b1; loopb = 1'b1; s_miso = 1'b0;
    bus.start = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.cs_sel = '0; bus.tx_data = '0;
    arm(8'h00, 1'b0, 1'b0, 0);
    prev_sclk = 1'b0; prev_mosi = 1'b1; prev_act = 1'b0; age = 0;
    repeat (3) step();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_sclk", 32'(bus.spi_clk), 32'd0);
    chk("rst_cs_n", 32'(bus.cs_n), 32'hF);
    chk("rst_mosi", 32'(bus.mosi), 32'd1);
    reset = 1'b0;
    run_frame(8'hA5, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_frame(8'h3C, 8'hC3, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    run_frame(8'hA5, 8'h00, 1'b0, 1'b0, 3, 1'b1, 1'b1);
    run_frame(8'($urandom), 8'($urandom), 1'b0, 1'b1, 2, 1'b0, 1'b0);
    run_frame(8'($urandom), 8'($urandom), 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_frame(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, NC - 1), 1'b0, 1'b0);
    // start held high: two back-to-back frames to slave 2
    tx = 8'($urandom);
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.cs_sel = 2'd2; bus.tx_data = tx; loopb = 1'b1;
    step();
    arm(8'h00, 1'b0, 1'b0, 2);
    vcnt = 0; hi_run = 0; min_gap = 999; csbad = 0; had_low = 1'b0;
    bus.start = 1'b1;
    for (int k = 0; k < 400 && vcnt < 2; k++) begin
      step();
      if (bus.rx_valid) begin
        vcnt++;
        chk("held_rx_data", 32'(bus.rx_data), 32'(tx));
      end
      if (bus.cs_n == 4'hF) hi_run++;
      else begin
        if (had_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        if (bus.cs_n != 4'b1011) csbad++;
        had_low = 1'b1;
        hi_run = 0;
      end
    end
    bus.start = 1'b0;
    chk("held_frames", 32'(vcnt), 32'd2);
    chk("held_cs_pattern", 32'(csbad), 32'd0);
    chk("held_cs_gap_ok", 32'(min_gap >= CD && min_gap < 999), 32'd1);
    chk("held_slave_rx", 32'(s_rx), 32'(tx));
    chk("held_rises", 32'(rises), 32'(2 * DW));
    for (int k = 0; k < 40 && !bus.ready; k++) step();
    chk("held_ready", 32'(bus.ready), 32'd1);
    // reset in the middle of a frame
    tx = 8'($urandom);
    bus.cs_sel = 2'd0; bus.tx_data = tx;
    step();
    arm(8'h00, 1'b0, 1'b0, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (30) step();
    reset = 1'b1;
    step();
    chk("mid_rst_cs_n", 32'(bus.cs_n), 32'hF);
    chk("mid_rst_sclk", 32'(bus.spi_clk), 32'd0);
    chk("mid_rst_mosi", 32'(bus.mosi), 32'd1);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    reset = 1'b0;
    vcnt = 0;
    repeat (100) begin
      step();
      if (bus.rx_valid) vcnt++;
    end
    chk("mid_rst_no_valid", 32'(vcnt), 32'd0);
    chk("mid_rst_rx_hold", 32'(bus.rx_data), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
